// File: rtl/reg_file_ctx.sv
// rtl/reg_file_ctx.sv - register file with accumulator, bypass reads and shadow context save/restore
//
// Purpose:
//   NUM_REGS x DATA_W general register file plus accumulator. Two combinational
//   read ports with write-to-read bypass. A single shadow bank holds a copy of
//   the whole context. Save/restore copies one register per cycle, then the
//   accumulator, while Busy blocks ordinary writes.
//
// Ports:
//   Reg_clk, Reg_rst       clock, asynchronous active-high reset
//   Wr_sel, RF_we, Data_in register write port
//   Rd_sel_a/b, Data_out_a/b  combinational read ports (out of range reads 0)
//   Acc_we, Acc_in, Acc_out   accumulator write port and registered value
//   Save_req, Restore_req     context operation requests, sampled when idle
//   Busy, Done                operation in progress / one-cycle completion pulse
//   Reg_flat                  debug tap, register i at [i*DATA_W +: DATA_W]

module reg_file_ctx #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic                       Reg_clk,
  input  logic                       Reg_rst,
  input  logic [ADDR_W-1:0]          Wr_sel,
  input  logic                       RF_we,
  input  logic [DATA_W-1:0]          Data_in,
  input  logic [ADDR_W-1:0]          Rd_sel_a,
  input  logic [ADDR_W-1:0]          Rd_sel_b,
  output logic [DATA_W-1:0]          Data_out_a,
  output logic [DATA_W-1:0]          Data_out_b,
  input  logic                       Acc_we,
  input  logic [DATA_W-1:0]          Acc_in,
  output logic [DATA_W-1:0]          Acc_out,
  input  logic                       Save_req,
  input  logic                       Restore_req,
  output logic                       Busy,
  output logic                       Done,
  output logic [DATA_W*NUM_REGS-1:0] Reg_flat
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAVE    = 2'd1,
    ST_RESTORE = 2'd2
  } state_t;

  // Copy index runs 0..NUM_REGS; the extra step at NUM_REGS moves the accumulator.
  localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W+1)'(NUM_REGS);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] regs_q   [NUM_REGS];
  logic [DATA_W-1:0] regs_d   [NUM_REGS];
  logic [DATA_W-1:0] shadow_q [NUM_REGS];
  logic [DATA_W-1:0] shadow_d [NUM_REGS];
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] sacc_q, sacc_d;

  logic              wr_ok;
  logic              copy_reg;
  logic [ADDR_W-1:0] copy_sel;

  assign Busy     = (state_q != ST_IDLE);
  assign Done     = done_q;
  assign Acc_out  = acc_q;

  // A register write lands only when idle and the index names a real register.
  assign wr_ok    = RF_we && !Busy && ({1'b0, Wr_sel} < IDX_LAST);
  assign copy_reg = (idx_q < IDX_LAST);
  assign copy_sel = idx_q[ADDR_W-1:0];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign Reg_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  // Bypass only applies to a write that will actually be accepted this edge.
  always_comb begin
    Data_out_a = '0;
    if ({1'b0, Rd_sel_a} < IDX_LAST) begin
      Data_out_a = (wr_ok && (Rd_sel_a == Wr_sel)) ? Data_in : regs_q[Rd_sel_a];
    end
  end

  always_comb begin
    Data_out_b = '0;
    if ({1'b0, Rd_sel_b} < IDX_LAST) begin
      Data_out_b = (wr_ok && (Rd_sel_b == Wr_sel)) ? Data_in : regs_q[Rd_sel_b];
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    regs_d   = regs_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    sacc_d   = sacc_q;
    case (state_q)
      ST_IDLE: begin
        // Writes in the request cycle land first, so a save captures them.
        if (wr_ok) begin
          regs_d[Wr_sel] = Data_in;
        end
        if (Acc_we) begin
          acc_d = Acc_in;
        end
        idx_d = '0;
        if (Save_req) begin
          state_d = ST_SAVE;
        end else if (Restore_req) begin
          state_d = ST_RESTORE;
        end
      end
      ST_SAVE, ST_RESTORE: begin
        if (copy_reg) begin
          if (state_q == ST_SAVE) begin
            shadow_d[copy_sel] = regs_q[copy_sel];
          end else begin
            regs_d[copy_sel] = shadow_q[copy_sel];
          end
          idx_d = idx_q + 1'b1;
        end else begin
          if (state_q == ST_SAVE) begin
            sacc_d = acc_q;
          end else begin
            acc_d = sacc_q;
          end
          idx_d   = '0;
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge Reg_clk or posedge Reg_rst) begin
    if (Reg_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      acc_q   <= '0;
      sacc_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      sacc_q   <= sacc_d;
      regs_q   <= regs_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: doc/reg_file_ctx.md
# reg_file_ctx

Parameterised general-purpose register file with accumulator and a single shadow context bank. Generalises the fixed four-register, 8-bit file to NUM_REGS registers of DATA_W bits. Adds two independent read ports, write-to-read bypass, and multi-cycle save/restore of the whole context (registers plus accumulator) to and from the shadow bank. Sits between the decoder/ALU datapath and the control unit; the control unit issues save/restore on interrupt entry/exit.

## Interface
- DATA_W, 8, register and accumulator width
- NUM_REGS, 4, number of general registers (2..256)
- ADDR_W, 2, select width; must equal clog2(NUM_REGS)

- Reg_clk  in  1  clock, all state updates on rising edge
- Reg_rst  in  1  reset, asynchronous, active-high
- Wr_sel  in  ADDR_W  write register index
- RF_we  in  1  register write enable
- Data_in  in  DATA_W  register write data
- Rd_sel_a / Rd_sel_b  in  ADDR_W  read port A/B index
- Data_out_a / Data_out_b  out  DATA_W  read port A/B data, combinational
- Acc_we  in  1  accumulator write enable
- Acc_in  in  DATA_W  accumulator write data
- Acc_out  out  DATA_W  accumulator value, combinational from register
- Save_req  in  1  start context save (sampled only when idle)
- Restore_req  in  1  start context restore (sampled only when idle)
- Busy  out  1  save/restore in progress; writes are dropped
- Done  out  1  one-cycle pulse, save/restore complete
- Reg_flat  out  DATA_W*NUM_REGS  debug tap; register i at bits [i*DATA_W +: DATA_W]

## Operation
- Reset (async, any state): all registers, Acc, shadow registers and shadow Acc become 0; FSM goes to IDLE; copy index becomes 0; Busy=0; Done=0. Reset during SAVE/RESTORE aborts with no partial results kept.
- Register write: at a rising edge with RF_we=1, Busy=0 and Wr_sel<NUM_REGS, reg[Wr_sel] <= Data_in. Out-of-range Wr_sel is ignored.
- Accumulator write: at a rising edge with Acc_we=1 and Busy=0, Acc <= Acc_in. Register and Acc writes in the same cycle are independent.
- Reads: Data_out_x = reg[Rd_sel_x]. If Rd_sel_x>=NUM_REGS, Data_out_x=0. Bypass: if RF_we=1, Busy=0 and Rd_sel_x==Wr_sel, Data_out_x=Data_in. There is no bypass on Acc_out.
- FSM states: IDLE, SAVE, RESTORE.
  - IDLE -> SAVE on Save_req=1. Save has priority when Save_req and Restore_req are both 1.
  - IDLE -> RESTORE on Restore_req=1 with Save_req=0.
  - Requests seen while not IDLE are ignored.
- SAVE: one copy per cycle, index 0..NUM_REGS-1: shadow[idx] <= reg[idx]. At idx==NUM_REGS: shadow_acc <= Acc, idx <= 0, FSM returns to IDLE.
- RESTORE: same sequence with the direction reversed; the final step sets Acc <= shadow_acc.
- A write accepted in the same cycle Save_req is sampled lands before copying begins, so the saved context includes it.
- Busy = (state != IDLE), decoded from registered state.
- Done is registered and high for exactly the one cycle after the FSM returns to IDLE.

## Timing
- Write latency: 1 edge; reads are combinational, with bypass giving 0-cycle write visibility.
- Request sampled at edge k:
  - Busy is high for cycles k..k+NUM_REGS (NUM_REGS+1 cycles).
  - Copies happen at edges k+1..k+NUM_REGS+1; the Acc copy is last.
  - Done is high for the cycle following edge k+NUM_REGS+1.
  - The first new write is accepted at edge k+NUM_REGS+2.
- A new request may be sampled in the Done cycle; back-to-back operations have no dead cycle.
- Reg_flat and Acc_out reflect each copy immediately after its edge.

## Test plan
- Reset/defaults: assert Reg_rst mid-cycle with regs preloaded.
  - All outputs 0, Busy=0, Done=0 immediately, without waiting for a clock edge.
- Write/bypass, DATA_W=8, NUM_REGS=4:
  - Write 0x5A to reg 2 with Rd_sel_a=2 in the same cycle -> Data_out_a=0x5A before the edge and after it.
  - Rd_sel_b=3 -> 0x00.
- Save/restore round trip:
  - Load regs 0x11,0x22,0x33,0x44 and Acc=0x99, then pulse Save_req.
  - Busy high 5 cycles, Done pulses once.
  - Overwrite all regs and Acc with 0xFF, then pulse Restore_req -> regs 0x11..0x44 and Acc=0x99 after 5 cycles.
- Blocked writes: RF_we=1 (reg1, 0xAB) and Acc_we=1 during SAVE -> reg1 and Acc unchanged.
  - Simultaneous Save_req+Restore_req -> SAVE taken.
- Reset mid-SAVE: assert Reg_rst at copy index 2.
  - Shadow all 0, FSM IDLE.
  - A following Restore yields all-zero regs and Acc.
- Parameter sweep DATA_W=16, NUM_REGS=8:
  - Write 0xBEEF to reg 7 -> Reg_flat[127:112]=0xBEEF.
  - SAVE has Busy high 9 cycles.
